pid_mac_scheduler: RTL and testbench

Time-multiplexed PID term scheduler for the temperature loop. It owns one bit-serial signed shift-add multiplier and sequences it over three products per sample: KP*e, KI*integ_hi and KD*de. The three products are accumulated, scaled and saturated into a 16-bit control word. It sits between the error-sample stage (setpoint minus sensor) and the PWM/heater drive stage.

---
 rtl/pid_mac_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pid_mac_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pid_mac_scheduler.sv
`default_nettype none
// pid_mac_scheduler: PID term scheduler sharing one bit-serial signed multiplier over KP*e, KI*integ_hi, KD*de.
// Rev 1.0 -- optional macro ANTI_WINDUP_EN enables conditional-integration anti-windup.
module pid_mac_scheduler #(
   parameter logic signed [15:0] KP        = 16'sd2048,
   parameter logic signed [15:0] KI        = 16'sd64,
   parameter logic signed [15:0] KD        = 16'sd512,
   parameter int unsigned        OUT_SHIFT = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [15:0] err,
   input  logic               clr_int,
   output logic               busy,
   output logic signed [15:0] u,
   output logic               u_valid,
   output logic               u_sat
);

   typedef enum logic [2:0] {S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_OUT} state_t;

   localparam logic signed [24:0] C_I_MAX = 25'sd8388607;
   localparam logic signed [24:0] C_I_MIN = -25'sd8388608;
   localparam logic signed [16:0] C_D_MAX = 17'sd32767;
   localparam logic signed [16:0] C_D_MIN = -17'sd32768;
   localparam logic signed [33:0] C_U_MAX = 34'sd32767;
   localparam logic signed [33:0] C_U_MIN = -34'sd32768;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic signed [33:0] acc_q, acc_d;
   logic signed [15:0] e_q, e_d, ihi_q, ihi_d, de_q, de_d, eprev_q, eprev_d, u_q, u_d;
   logic signed [23:0] integ_q, integ_d;
   logic               uval_q, uval_d, usat_q, usat_d;

   logic signed [23:0] w_ibase, w_inew;
   logic signed [24:0] w_isum;
   logic signed [16:0] w_dsum;
   logic signed [15:0] w_de, w_k, w_op, w_uval;
   logic signed [33:0] w_kshift, w_shr;
   logic               w_hold, w_clamp;

   // Integrator: clear is applied before accumulation when both arrive together.
   always_comb begin
      w_ibase = clr_int ? 24'sd0 : integ_q;
      w_isum  = {w_ibase[23], w_ibase} + {{9{err[15]}}, err};
`ifdef ANTI_WINDUP_EN
      w_hold  = usat_q && (err[15] == u_q[15]);
`else
      w_hold  = 1'b0;
`endif
      if (w_hold)                w_inew = w_ibase;
      else if (w_isum > C_I_MAX) w_inew = C_I_MAX[23:0];
      else if (w_isum < C_I_MIN) w_inew = C_I_MIN[23:0];
      else                       w_inew = w_isum[23:0];

      w_dsum = {err[15], err} - {eprev_q[15], eprev_q};
      if (w_dsum > C_D_MAX)      w_de = 16'sh7FFF;
      else if (w_dsum < C_D_MIN) w_de = 16'sh8000;
      else                       w_de = w_dsum[15:0];
   end

   always_comb begin
      case (state_q)
         S_MUL1:  begin w_k = KI; w_op = ihi_q; end
         S_MUL2:  begin w_k = KD; w_op = de_q;  end
         default: begin w_k = KP; w_op = e_q;   end
      endcase
      w_kshift = {{18{w_k[15]}}, w_k} <<< cnt_q;
      w_shr    = acc_q >>> OUT_SHIFT;
      w_clamp  = 1'b1;
      if (w_shr > C_U_MAX)      w_uval = 16'sh7FFF;
      else if (w_shr < C_U_MIN) w_uval = 16'sh8000;
      else begin
         w_uval  = w_shr[15:0];
         w_clamp = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      e_d     = e_q;
      ihi_d   = ihi_q;
      de_d    = de_q;
      eprev_d = eprev_q;
      integ_d = integ_q;
      u_d     = u_q;
      usat_d  = usat_q;
      uval_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               e_d     = err;
               integ_d = w_inew;
               ihi_d   = w_inew[23:8];
               de_d    = w_de;
               eprev_d = err;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_MUL0;
            end else if (clr_int) begin
               integ_d = '0;
            end
         end
         S_MUL0, S_MUL1, S_MUL2: begin
            // Bit 15 carries negative weight in two's complement.
            if (w_op[cnt_q])
               acc_d = (cnt_q == 4'd15) ? acc_q - w_kshift : acc_q + w_kshift;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               case (state_q)
                  S_MUL0:  state_d = S_MUL1;
                  S_MUL1:  state_d = S_MUL2;
                  default: state_d = S_OUT;
               endcase
            end
         end
         S_OUT: begin
            u_d     = w_uval;
            usat_d  = w_clamp;
            uval_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         e_q     <= '0;
         ihi_q   <= '0;
         de_q    <= '0;
         eprev_q <= '0;
         integ_q <= '0;
         u_q     <= '0;
         usat_q  <= 1'b0;
         uval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         e_q     <= e_d;
         ihi_q   <= ihi_d;
         de_q    <= de_d;
         eprev_q <= eprev_d;
         integ_q <= integ_d;
         u_q     <= u_d;
         usat_q  <= usat_d;
         uval_q  <= uval_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign u       = u_q;
   assign u_valid = uval_q;
   assign u_sat   = usat_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_mac_scheduler.sv
`default_nettype none
// tb_pid_mac_scheduler: scoreboard bench with an arithmetic PID reference model.
module tb_pid_mac_scheduler;

   localparam longint KP = 2048;
   localparam longint KI = 64;
   localparam longint KD = 512;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic signed [15:0] err = '0;
   logic               clr_int = 1'b0;
   logic               busy, u_valid, u_sat;
   logic signed [15:0] u;

   pid_mac_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .err(err), .clr_int(clr_int),
      .busy(busy), .u(u), .u_valid(u_valid), .u_sat(u_sat)
   );

   always #5 clk = ~clk;

   typedef struct {longint u; bit s; longint t;} exp_t;
   exp_t   sbq[$];
   int     total = 0;
   int     bad = 0;
   longint cyc = 0;

   // reference model state
   longint m_integ = 0, m_eprev = 0, m_u = 0;
   bit     m_sat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint sat(longint v, longint lo, longint hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic check(string name, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a result.
   always @(negedge clk) begin
      if (!rst && u_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_u_valid", 1, 0);
         end else begin
            exp_t x;
            x = sbq.pop_front();
            check("u", longint'(u), x.u);
            check("u_sat", longint'(u_sat), longint'(x.s));
            check("latency", cyc - x.t, 50);
            check("busy_at_valid", longint'(busy), 0);
         end
      end
   end

   task automatic model_accept(longint e, bit clr);
      longint base, acc, y;
      bit hold;
      exp_t x;
      base = clr ? 0 : m_integ;
      hold = 1'b0;
`ifdef ANTI_WINDUP_EN
      hold = m_sat && ((e < 0) == (m_u < 0));
`endif
      m_integ = hold ? base : sat(base + e, -8388608, 8388607);
      acc = KP * e + KI * (m_integ >>> 8) + KD * sat(e - m_eprev, -32768, 32767);
      m_eprev = e;
      y = acc >>> 11;
      m_u = sat(y, -32768, 32767);
      m_sat = (y != m_u);
      x.u = m_u;
      x.s = m_sat;
      x.t = cyc;
      sbq.push_back(x);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("wait_idle_timeout", 1, 0);
   endtask

   task automatic do_sample(longint e, bit clr);
      @(negedge clk);
      wait_idle();
      start = 1'b1;
      err = 16'(e);
      clr_int = clr;
      model_accept(e, clr);
      @(negedge clk);
      start = 1'b0;
      clr_int = 1'b0;
   endtask

   task automatic do_idle_clear();
      @(negedge clk);
      wait_idle();
      clr_int = 1'b1;
      m_integ = 0;
      @(negedge clk);
      clr_int = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      m_integ = 0; m_eprev = 0; m_u = 0; m_sat = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_u", longint'(u), 0);
      check("rst_u_sat", longint'(u_sat), 0);
      check("rst_u_valid", longint'(u_valid), 0);
      check("rst_busy", longint'(busy), 0);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sbq.size(), 0);
   endtask

   initial begin
      do_reset();
      do_sample(100, 0);
      do_sample(100, 0);
      drain();

      do_reset();
      do_sample(-100, 0);
      drain();

      do_reset();
      do_sample(32767, 0);
      do_sample(-32768, 0);
      do_sample(32767, 0);
      drain();

      // start and clr_int while busy must be ignored
      do_sample(3000, 0);
      do_sample(1234, 0);
      repeat (10) @(negedge clk);
      start = 1'b1; err = -16'sd7777; clr_int = 1'b1;
      @(negedge clk);
      start = 1'b0; clr_int = 1'b0;
      do_sample(500, 0);
      drain();

      // reset mid-sample aborts without a result
      do_sample(2000, 0);
      repeat (20) @(negedge clk);
      do_reset();
      repeat (60) @(negedge clk);
      check("abort_busy", longint'(busy), 0);
      check("abort_u", longint'(u), 0);

      for (int i = 0; i < 257; i++) do_sample(32767, 0);
      do_sample(-20000, 0);
      do_sample(5, 1);
      do_sample(5, 0);
      drain();

      for (int i = 0; i < 60; i++) begin
         longint e;
         if ($urandom_range(0, 3) == 0) e = longint'($signed(16'($urandom())));
         else e = longint'($urandom_range(0, 1000)) - 500;
         if ($urandom_range(0, 9) == 0) do_idle_clear();
         do_sample(e, $urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
